imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Writer side of the instruction memory: turns a byte stream (UART RX or TB) into 32-bit word writes on the instruction RAM write port.
// - Holds the core in reset until a full image is loaded; the core then fetches via addr[31:2] indexing.
// - Frame: 0xA5 sync, word count N (16b little-endian), N words of 4 bytes each, LSB first.
// PARAMETERS
// - ADDR_W     8   word-address bits of target memory (capacity 2**ADDR_W words)
// - BASE_WORD  0   word index written by first payload word
// PORTS
// - clk        in   1   system clock, rising edge
// - reset      in   1   asynchronous, active-high
// - rx_data    in   8   incoming byte
// - rx_valid   in   1   rx_data valid this cycle
// - rx_ready   out  1   loader can accept a byte
// - we         out  1   one-cycle write strobe to instruction RAM
// - waddr      out  32  byte address of write, = (BASE_WORD+idx)<<2, bits[1:0]=0
// - wdata      out  32  assembled word
// - cpu_hold   out  1   1 = keep core in reset
// - load_done  out  1   image loaded; sticky until next sync byte or reset
// - load_err   out  1   frame error; sticky until next sync byte or reset
// BEHAVIOUR
// - Reset values: we=0, waddr=0, wdata=0, cpu_hold=1, load_done=0, load_err=0; state=IDLE.
// - Byte accepted only when rx_valid && rx_ready. rx_ready=1 in every state, so no backpressure; rx_ready=0 only while reset is asserted.
// - States: IDLE, CNT_LO, CNT_HI, DATA, [CHK], DONE, ERR.
// - IDLE: 0xA5 -> CNT_LO; any other byte is discarded.
// - CNT_LO -> CNT_HI: latch N[7:0]. CNT_HI: latch N[15:8], then:
//   - N==0 -> DONE.
//   - N > 2**ADDR_W - BASE_WORD -> ERR.
//   - otherwise -> DATA; idx=0, byte_cnt=0.
// - DATA: byte k of a word goes to bits [8k+7:8k] (little-endian).
//   - 4th byte: next cycle we=1, wdata=word, waddr=(BASE_WORD+idx)<<2.
//   - we lasts exactly one cycle; latency is 1 clk from accepting the 4th byte.
//   - Back-to-back 4th bytes give back-to-back we pulses.
//   - After word N-1 -> CHK (if enabled) else DONE.
// - DONE: load_done=1, cpu_hold=0 in the same cycle the last we is issued (last word committed on that edge).
// - ERR: load_err=1, cpu_hold=1; no writes.
// - DONE/ERR: 0xA5 restarts the load: clear load_done/load_err, cpu_hold=1, -> CNT_LO. Other bytes are ignored.
// - Sync byte inside DATA is treated as payload, never as a restart.
// - Reset mid-load: all state cleared immediately (async), partial image stays in RAM, cpu_hold=1.
// - Counters: idx is ADDR_W+1 bits, byte_cnt is 2 bits and wraps 3->0. waddr upper bits are zero-extended.
// CONFIGURATION
// - IMEM_LOADER_CHECKSUM_EN defined:
//   - After the last payload byte, CHK accepts one byte equal to the XOR of all 4N payload bytes.
//   - Match -> DONE. Mismatch -> ERR with load_err=1, cpu_hold stays 1; words already written are not undone.
//   - N==0 still goes directly to DONE with no checksum byte.
// - Macro undefined: no CHK state; DONE follows the last word directly.
// TESTING
// - Reset, then A5 02 00 13 00 50 00 B3 80 20 00 -> we at waddr 0x0 wdata 0x00500013, waddr 0x4 wdata 0x002080B3; load_done=1, cpu_hold=0.
// - Junk 00 FF 12, then A5 01 00 78 56 34 12 -> junk ignored, one write of 0x12345678 @0x0.
// - A5 01 01 (N=257, ADDR_W=8, BASE_WORD=0) -> load_err=1, cpu_hold=1, no we.
// - A5 00 00 -> load_done=1 immediately, no we; then A5 01 00 EF BE AD DE -> done cleared, hold=1, write 0xDEADBEEF @0x0, done again.
// - Reset asserted after 2 of 4 words -> outputs at reset values same cycle; new frame loads from idx 0.
// - CHECKSUM_EN: A5 01 00 01 02 04 08 0F -> DONE. Same frame with checksum 0E -> ERR, word still written once.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_if
//  Purpose  : Byte-stream input and instruction-RAM write port of the
//             instruction memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;

   // Loader side: consumes bytes, drives the RAM write port
   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, we, waddr, wdata
   );

   // Environment side: produces bytes, observes the RAM write port
   modport master (
      output rx_data, rx_valid,
      input  rx_ready, we, waddr, wdata
   );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Turns a framed byte stream (0xA5, N[15:0] LE, N x 4-byte LE
//             words) into 32-bit instruction RAM writes and holds the core
//             in reset until the image is complete.
//  Options  : IMEM_LOADER_CHECKSUM_EN - trailing XOR checksum byte checked
//             after the payload (CHK state).
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_WORD = 0
) (
   input  wire logic     clk,
   input  wire logic     reset,
   imem_loader_if.slave  bus,
   output logic          cpu_hold,
   output logic          load_done,
   output logic          load_err
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_CNT_LO = 3'd1;
   localparam logic [2:0] c_CNT_HI = 3'd2;
   localparam logic [2:0] c_DATA   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] c_CHK    = 3'd4;
`endif
   localparam logic [2:0] c_DONE   = 3'd5;
   localparam logic [2:0] c_ERR    = 3'd6;

   localparam logic [7:0]  c_SYNC = 8'hA5;
   // Largest word count that still fits above BASE_WORD
   localparam logic [31:0] c_CAP  = 32'((2 ** ADDR_W) - BASE_WORD);

   logic [2:0]        r_state;
   logic [15:0]       r_cnt;
   logic [ADDR_W:0]   r_idx;
   logic [1:0]        r_byte_cnt;
   logic [23:0]       r_word;
   logic              r_we;
   logic [31:0]       r_waddr;
   logic [31:0]       r_wdata;
   logic              r_hold;
   logic              r_done;
   logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        r_csum;
`endif

   logic              w_acc;
   logic [15:0]       w_n;
   logic              w_last;

   // No backpressure: ready whenever reset is released
   assign bus.rx_ready = ~reset;
   assign w_acc        = bus.rx_valid & ~reset;
   assign w_n          = {bus.rx_data, r_cnt[7:0]};
   assign w_last       = ((32'(r_idx) + 32'd1) == 32'(r_cnt));

   assign bus.we    = r_we;
   assign bus.waddr = r_waddr;
   assign bus.wdata = r_wdata;
   assign cpu_hold  = r_hold;
   assign load_done = r_done;
   assign load_err  = r_err;

   // Frame parser, word assembler and write-port driver
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_byte_cnt <= '0;
         r_word     <= '0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_hold     <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         if (w_acc) begin
            case (r_state)
               c_IDLE: begin
                  if (bus.rx_data == c_SYNC) r_state <= c_CNT_LO;
               end
               c_CNT_LO: begin
                  r_cnt[7:0] <= bus.rx_data;
                  r_state    <= c_CNT_HI;
               end
               c_CNT_HI: begin
                  r_cnt[15:8] <= bus.rx_data;
                  if (w_n == 16'd0) begin
                     r_state <= c_DONE;
                     r_done  <= 1'b1;
                     r_hold  <= 1'b0;
                  end else if (32'(w_n) > c_CAP) begin
                     r_state <= c_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state    <= c_DATA;
                     r_idx      <= '0;
                     r_byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_csum     <= '0;
`endif
                  end
               end
               c_DATA: begin
                  // Sync byte here is ordinary payload
                  r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum     <= r_csum ^ bus.rx_data;
`endif
                  case (r_byte_cnt)
                     2'd0: r_word[7:0]   <= bus.rx_data;
                     2'd1: r_word[15:8]  <= bus.rx_data;
                     2'd2: r_word[23:16] <= bus.rx_data;
                     default: begin
                        r_we    <= 1'b1;
                        r_wdata <= {bus.rx_data, r_word};
                        r_waddr <= (32'(BASE_WORD) + 32'(r_idx)) << 2;
                        r_idx   <= r_idx + 1'b1;
                        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                           r_state <= c_CHK;
`else
                           // Release the core on the edge the last word commits
                           r_state <= c_DONE;
                           r_done  <= 1'b1;
                           r_hold  <= 1'b0;
`endif
                        end
                     end
                  endcase
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               c_CHK: begin
                  if (bus.rx_data == r_csum) begin
                     r_state <= c_DONE;
                     r_done  <= 1'b1;
                     r_hold  <= 1'b0;
                  end else begin
                     r_state <= c_ERR;
                     r_err   <= 1'b1;
                  end
               end
`endif
               c_DONE, c_ERR: begin
                  if (bus.rx_data == c_SYNC) begin
                     r_state <= c_CNT_LO;
                     r_done  <= 1'b0;
                     r_err   <= 1'b0;
                     r_hold  <= 1'b1;
                  end
               end
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader: frame table plus
//             hand-written reset, capacity and checksum sequences; RAM writes
//             are compared against a queue of expected writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   logic clk = 1'b0;
   logic reset;
   logic cpu_hold, load_done, load_err;

   imem_loader_if bus ();

   imem_loader #(.ADDR_W(8), .BASE_WORD(0)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [0:11][7:0] b;
      logic [3:0]       nb;
      logic [1:0]       nw;
      logic [0:1][31:0] a;
      logic [0:1][31:0] d;
      logic             done;
      logic             err;
      logic             hold;
   } vec_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   vec_t vecs [8];
   wr_t  sbq [$];
   wr_t  mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every write strobe must match the head of the expected-write queue
   always @(posedge clk) begin
      #1;
      if (bus.we === 1'b1) begin
         if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.waddr, bus.wdata);
         end else begin
            mon_e = sbq.pop_front();
            check("waddr", bus.waddr, mon_e.a);
            check("wdata", bus.wdata, mon_e.d);
         end
      end
   end

   task automatic put(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      sbq.push_back(e);
   endtask

   function automatic logic [7:0] xor4(input logic [31:0] d);
      return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
   endfunction

   task automatic status(input string tag, input logic done, input logic err, input logic hold);
      check({tag, "_done"}, 32'(load_done), 32'(done));
      check({tag, "_err"},  32'(load_err),  32'(err));
      check({tag, "_hold"}, 32'(cpu_hold),  32'(hold));
      check({tag, "_sb_empty"}, sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      logic [7:0]  cs;
      logic [31:0] d;

      vecs[0] = '{b: 96'hA5_02_00_13_00_50_00_B3_80_20_00_00, nb: 4'd11, nw: 2'd2,
                  a: {32'h0, 32'h4}, d: {32'h00500013, 32'h002080B3},
                  done: 1'b1, err: 1'b0, hold: 1'b0};
      vecs[1] = '{b: 96'h00_FF_12_A5_01_00_78_56_34_12_00_00, nb: 4'd10, nw: 2'd1,
                  a: {32'h0, 32'h0}, d: {32'h12345678, 32'h0},
                  done: 1'b1, err: 1'b0, hold: 1'b0};
      vecs[2] = '{b: 96'hA5_01_01_00_00_00_00_00_00_00_00_00, nb: 4'd3, nw: 2'd0,
                  a: '0, d: '0, done: 1'b0, err: 1'b1, hold: 1'b1};
      vecs[3] = '{b: 96'h00_55_A5_00_00_00_00_00_00_00_00_00, nb: 4'd5, nw: 2'd0,
                  a: '0, d: '0, done: 1'b1, err: 1'b0, hold: 1'b0};
      vecs[4] = '{b: 96'hA5_01_00_EF_BE_AD_DE_00_00_00_00_00, nb: 4'd7, nw: 2'd1,
                  a: {32'h0, 32'h0}, d: {32'hDEADBEEF, 32'h0},
                  done: 1'b1, err: 1'b0, hold: 1'b0};
      vecs[5] = '{b: 96'hA5_01_00_A5_A5_A5_A5_00_00_00_00_00, nb: 4'd7, nw: 2'd1,
                  a: {32'h0, 32'h0}, d: {32'hA5A5A5A5, 32'h0},
                  done: 1'b1, err: 1'b0, hold: 1'b0};
      vecs[6] = '{b: 96'hA5_FF_FF_00_00_00_00_00_00_00_00_00, nb: 4'd3, nw: 2'd0,
                  a: '0, d: '0, done: 1'b0, err: 1'b1, hold: 1'b1};
      vecs[7] = '{b: 96'hA5_02_00_01_02_03_04_05_06_07_08_00, nb: 4'd11, nw: 2'd2,
                  a: {32'h0, 32'h4}, d: {32'h04030201, 32'h08070605},
                  done: 1'b1, err: 1'b0, hold: 1'b0};

      // Reset values
      reset        = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #12;
      check("rst_we",    32'(bus.we), 32'd0);
      check("rst_waddr", bus.waddr, 32'h0);
      check("rst_wdata", bus.wdata, 32'h0);
      check("rst_ready", 32'(bus.rx_ready), 32'd0);
      status("rst", 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("ready_after_rst", 32'(bus.rx_ready), 32'd1);

      // Frame table
      for (int i = 0; i < 8; i++) begin
         cs = 8'h00;
         for (int w = 0; w < int'(vecs[i].nw); w++) begin
            push(vecs[i].a[w], vecs[i].d[w]);
            cs = cs ^ xor4(vecs[i].d[w]);
         end
         for (int k = 0; k < int'(vecs[i].nb); k++) put(vecs[i].b[k]);
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (vecs[i].nw != 2'd0) put(cs);
`endif
         idle();
         status($sformatf("vec%0d", i), vecs[i].done, vecs[i].err, vecs[i].hold);
      end

      // Sync byte in DONE clears done and re-asserts hold
      put(8'hA5);
      idle();
      status("resync", 1'b0, 1'b0, 1'b1);
      push(32'h0, 32'hCAFEF00D);
      put(8'h01); put(8'h00);
      put(8'h0D); put(8'hF0); put(8'hFE); put(8'hCA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      put(xor4(32'hCAFEF00D));
`endif
      idle();
      status("resync_load", 1'b1, 1'b0, 1'b0);

      // Full-capacity image: N = 256 words
      cs = 8'h00;
      for (int i = 0; i < 256; i++) push(32'(i) << 2, 32'hC0DE0000 | 32'(i));
      put(8'hA5); put(8'h00); put(8'h01);
      for (int i = 0; i < 256; i++) begin
         d  = 32'hC0DE0000 | 32'(i);
         cs = cs ^ xor4(d);
         put(d[7:0]); put(d[15:8]); put(d[23:16]); put(d[31:24]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      put(cs);
`endif
      idle();
      check("cap_last_waddr", bus.waddr, 32'h3FC);
      status("cap", 1'b1, 1'b0, 1'b0);

      // Reset after 2 of 4 words
      push(32'h0, 32'h13121110);
      push(32'h4, 32'h17161514);
      put(8'hA5); put(8'h04); put(8'h00);
      for (int k = 0; k < 8; k++) put(8'h10 + 8'(k));
      idle();
      check("mid_sb_empty", sbq.size(), 0);
      #2;
      reset = 1'b1;
      #1;
      check("mid_we",    32'(bus.we), 32'd0);
      check("mid_waddr", bus.waddr, 32'h0);
      check("mid_wdata", bus.wdata, 32'h0);
      check("mid_ready", 32'(bus.rx_ready), 32'd0);
      status("mid_rst", 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      push(32'h0, 32'h11223344);
      put(8'hA5); put(8'h01); put(8'h00);
      put(8'h44); put(8'h33); put(8'h22); put(8'h11);
`ifdef IMEM_LOADER_CHECKSUM_EN
      put(xor4(32'h11223344));
`endif
      idle();
      status("post_rst", 1'b1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Correct and wrong checksum byte
      push(32'h0, 32'h08040201);
      put(8'hA5); put(8'h01); put(8'h00);
      put(8'h01); put(8'h02); put(8'h04); put(8'h08); put(8'h0F);
      idle();
      status("chk_ok", 1'b1, 1'b0, 1'b0);
      push(32'h0, 32'h08040201);
      put(8'hA5); put(8'h01); put(8'h00);
      put(8'h01); put(8'h02); put(8'h04); put(8'h08); put(8'h0E);
      idle();
      status("chk_bad", 1'b0, 1'b1, 1'b1);
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
